// File: rtl/img2col_pkg.sv
// Shared definitions for the img2col datapath: feeder state encoding and
// default geometry constants.
package img2col_pkg;

    // Default pixel width, register file depth and write-address width.
    localparam int IMG2COL_DW   = 16;
    localparam int IMG2COL_REGS = 5;
    localparam int IMG2COL_AW   = 5;

    // Width of row_len, the pixel counter and win_idx (rows up to 63 pixels).
    localparam int IMG2COL_LENW = 6;

    // Write-side sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        SETTLE = 3'd2,
        READ   = 3'd3,
        SLIDE  = 3'd4,
        DONE   = 3'd5
    } feeder_state_t;

endpackage

// File: rtl/regfile_feeder_if.sv
// Bundle between a pixel source and the register-file feeder.
//
// Handshake: a pixel transfers on a posedge where pix_valid && pix_ready are
// both high. pix_ready depends only on feeder state, never on pix_valid, and
// the source may raise or drop pix_valid at any time; data is taken only on
// a transfer edge. start is a level sampled only while the feeder is idle.
interface regfile_feeder_if
    import img2col_pkg::*;
#(
    parameter int data_width  = IMG2COL_DW,
    parameter int address_num = IMG2COL_AW
);

    // Row control
    logic                    start;
    logic [IMG2COL_LENW-1:0] row_len;

    // Pixel stream
    logic [data_width-1:0]   pix_in;
    logic                    pix_valid;
    logic                    pix_ready;

    // Register file write side
    logic [data_width-1:0]   in1;
    logic [address_num-1:0]  adrs_in1;
    logic                    wr_ctrl;
    logic                    act;
    logic                    r_ctrl;

    // Row status
    logic [IMG2COL_LENW-1:0] win_idx;
    logic                    done;
    logic                    err;

    // Pixel source / row controller side.
    modport master (
        output start, row_len, pix_in, pix_valid,
        input  pix_ready, in1, adrs_in1, wr_ctrl, act, r_ctrl,
        input  win_idx, done, err
    );

    // Feeder side.
    modport slave (
        input  start, row_len, pix_in, pix_valid,
        output pix_ready, in1, adrs_in1, wr_ctrl, act, r_ctrl,
        output win_idx, done, err
    );

endinterface

// File: rtl/regfile_feeder.sv
// Write-side sequencer for the img2col single-input register file. The first
// reg_num pixels of a row are written by address, every later pixel is
// shifted in, and once the file is full each pixel triggers one window read.
module regfile_feeder
    import img2col_pkg::*;
#(
    parameter int data_width  = IMG2COL_DW,
    parameter int reg_num     = IMG2COL_REGS,
    parameter int address_num = IMG2COL_AW
) (
    input  logic          clk,
    input  logic          rst,
    regfile_feeder_if.slave bus,
    output feeder_state_t dbg_state
);

    localparam logic [IMG2COL_LENW-1:0] REG_NUM_L = IMG2COL_LENW'(reg_num);
    localparam logic [IMG2COL_LENW-1:0] LAST_FILL = IMG2COL_LENW'(reg_num - 1);

    feeder_state_t           state;
    logic [IMG2COL_LENW-1:0] cnt;
    logic [IMG2COL_LENW-1:0] len_q;
    logic [IMG2COL_LENW-1:0] win_q;
    logic [data_width-1:0]   in1_q;
    logic [address_num-1:0]  adrs_q;
    logic                    wr_ctrl_q;
    logic                    act_q;
    logic                    r_ctrl_q;
    logic                    done_q;
    logic                    err_q;

    // Ready is a pure state decode so the source sees it without pixel dependence.
    assign bus.pix_ready = (state == FILL) || (state == SLIDE);

    assign bus.in1      = in1_q;
    assign bus.adrs_in1 = adrs_q;
    assign bus.wr_ctrl  = wr_ctrl_q;
    assign bus.act      = act_q;
    assign bus.r_ctrl   = r_ctrl_q;
    assign bus.win_idx  = win_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign dbg_state    = state;

    // Sequencer: state, pixel counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            win_q     <= '0;
            in1_q     <= '0;
            adrs_q    <= '0;
            wr_ctrl_q <= 1'b0;
            act_q     <= 1'b0;
            r_ctrl_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle; address parks at 0 between writes.
            wr_ctrl_q <= 1'b0;
            act_q     <= 1'b0;
            r_ctrl_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            adrs_q    <= '0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.row_len;
                        cnt   <= '0;
                        win_q <= '0;
                        // A row shorter than the file can never form a window.
                        if (bus.row_len < REG_NUM_L) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (bus.pix_valid) begin
                        in1_q     <= bus.pix_in;
                        adrs_q    <= address_num'(cnt);
                        wr_ctrl_q <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        // Stay here for back-to-back writes until the file is full.
                        if (cnt == LAST_FILL) begin
                            state <= SETTLE;
                        end
                    end
                end

                SLIDE: begin
                    if (bus.pix_valid) begin
                        in1_q <= bus.pix_in;
                        act_q <= 1'b1;
                        cnt   <= cnt + 1'b1;
                        state <= SETTLE;
                    end
                end

                SETTLE: begin
                    // The write/shift happens this cycle; the read follows it.
                    r_ctrl_q <= 1'b1;
                    win_q    <= win_q + 1'b1;
                    state    <= READ;
                end

                READ: begin
                    if (cnt == len_q) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= SLIDE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The three register-file strobes never overlap.
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({wr_ctrl_q, act_q, r_ctrl_q}));

    // A read is only ever issued from the settle cycle.
    a_read_in_read: assert property (@(posedge clk) disable iff (rst)
        r_ctrl_q |-> (state == READ));

endmodule
